dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter sharing the single-port data memory between the CPU load/store unit (master 0) and the UART boot/debug loader (master 1). It issues at most one memory access per cycle, chosen round-robin on contention. A master may lock ownership for short bursts, subject to a bounded hold limit. Read data is registered and returned to the granted master one cycle after grant. The block sits between both masters and the data_memory instance.

Parameters:
- ADDR_W, 32, address width of both masters and the memory side
- DATA_W, 32, data width
- MAX_HOLD, 8, maximum consecutive locked grants to one master while the other is requesting (1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write enable (0 = read)
- m0_lock  in  1  master 0 requests to keep ownership after this access
- m0_addr  in  ADDR_W  master 0 byte address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  master 0 access accepted this cycle (combinational)
- m0_rvalid  out  1  master 0 read data valid (registered)
- m0_rdata  out  DATA_W  master 0 read data (registered)
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for master 1
- mem_write  out  1  to data memory MemWrite
- mem_read  out  1  to data memory MemRead
- mem_addr  out  ADDR_W  to data memory addr
- mem_wdata  out  DATA_W  to data memory write_data
- mem_rdata  in  DATA_W  from data memory read_data (combinational)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; last_grant=1, so m0 wins the first tie; hold_cnt=0; m*_rvalid=0; m*_rdata=0. All gnt, mem_write and mem_read outputs are 0 while in reset.
- Grant is combinational from req, state and last_grant. Exactly zero or one of m0_gnt/m1_gnt is high. A request is accepted in the cycle gnt=1. The master must hold req/we/addr/wdata stable until gnt.
- Muxing: on grant, mem_addr/mem_wdata come from the winner. mem_write = gnt & we; mem_read = gnt & ~we. With no grant, mem_addr=0, mem_wdata=0, mem_write=0, mem_read=0.
- Latency:
  - Write: committed at the clk edge ending the grant cycle; no rvalid.
  - Read: mem_rdata is captured at the end of the grant cycle. mN_rvalid=1 and mN_rdata are valid for exactly one cycle (N+1). The other master's rvalid stays 0 and its rdata holds its last value.
- States:
  - IDLE:
    - One requester: grant it.
    - Both requesting: grant the master != last_grant.
    - If the winner's lock=1, go to OWN_Mx with hold_cnt=1.
  - OWN_M0 / OWN_M1:
    - Owner requesting and hold_cnt<MAX_HOLD: owner granted regardless of the other's req. hold_cnt increments on each owner grant while the other master is requesting; it is held when the other is idle.
    - Owner granted with lock=0: return to IDLE after that access.
    - Owner req=0: return to IDLE; same-cycle arbitration as IDLE, so no bubble.
    - hold_cnt==MAX_HOLD and other requesting: owner not granted. The other master is granted and the FSM re-enters IDLE semantics with last_grant=other; the forced yield lasts one access.
- last_grant updates on every grant. hold_cnt clears on leaving OWN_*.
- Simultaneous grant and rvalid to the same master: allowed, so back-to-back reads achieve throughput of 1 per cycle.
- Reset mid-burst: ownership is dropped, any pending rvalid is lost, and a write granted in the reset cycle is not performed (mem_write=0).
- Address bits are passed unchanged; word indexing is done by the memory.

Decomposition:
- Shared package (dmem_pkg): state encoding (IDLE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2), ADDR_W/DATA_W defaults, master index constants M0=0, M1=1.
- No sub-module is required; a small rr_pick function (two requests, last_grant) selects the winner.

Test Plan:
- Only m0 reads addr 0x10 holding 0xDEADBEEF: m0_gnt same cycle, m0_rvalid=1 with m0_rdata=0xDEADBEEF next cycle, m1_rvalid=0.
- Both masters request reads continuously with lock=0 after reset: grants alternate m0,m1,m0,m1; each rvalid is one cycle after its grant.
- m1 writes 0x55 to 0x20 while m0 idle, then m0 reads 0x20: mem_write high for one cycle; m0_rdata=0x00000055.
- m0 locks and requests continuously while m1 requests, MAX_HOLD=4: m0 granted 4 consecutive cycles, m1 granted the 5th, then m0 regains per round-robin.
- Locked m0 drops req mid-burst while m1 requesting: m1_gnt in the same cycle; state returns to IDLE.
- rst_n pulsed low during a locked burst with a read outstanding: all gnt/rvalid drop immediately; after release, the first tie goes to m0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default widths,
// master indices and the round-robin pick helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // On a tie the master that did not win last time is chosen.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
        if (req0 && req1) begin
            return ~last_grant;
        end else if (req1) begin
            return M1;
        end else begin
            return M0;
        end
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU LSU
// (master 0) and the UART loader (master 1), with bounded lock ownership.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state, state_nx;
    logic       last_grant, last_nx;
    logic [7:0] hold_cnt, hold_nx;
    logic       gnt0_c, gnt1_c;
    logic       arb, win;
    logic       hold_max;
    logic       rd0_p0, rd1_p0;

    assign hold_max = (hold_cnt >= HOLD_LIM);

    always_comb begin
        gnt0_c   = 1'b0;
        gnt1_c   = 1'b0;
        state_nx = state;
        hold_nx  = hold_cnt;
        last_nx  = last_grant;
        arb      = 1'b0;
        win      = M0;

        case (state)
            OWN_M0: begin
                if (m0_req && !(hold_max && m1_req)) begin
                    gnt0_c  = 1'b1;
                    last_nx = M0;
                    if (m0_lock) begin
                        if (m1_req) hold_nx = hold_cnt + 8'd1;
                    end else begin
                        state_nx = IDLE;
                        hold_nx  = 8'd0;
                    end
                end else if (!m0_req) begin
                    arb = 1'b1;
                end else begin
                    // Hold limit reached with the other master waiting: one forced access.
                    gnt1_c   = 1'b1;
                    last_nx  = M1;
                    state_nx = IDLE;
                    hold_nx  = 8'd0;
                end
            end
            OWN_M1: begin
                if (m1_req && !(hold_max && m0_req)) begin
                    gnt1_c  = 1'b1;
                    last_nx = M1;
                    if (m1_lock) begin
                        if (m0_req) hold_nx = hold_cnt + 8'd1;
                    end else begin
                        state_nx = IDLE;
                        hold_nx  = 8'd0;
                    end
                end else if (!m1_req) begin
                    arb = 1'b1;
                end else begin
                    gnt0_c   = 1'b1;
                    last_nx  = M0;
                    state_nx = IDLE;
                    hold_nx  = 8'd0;
                end
            end
            default: arb = 1'b1;
        endcase

        // Open arbitration, also used when an owner releases without a bubble.
        if (arb) begin
            state_nx = IDLE;
            hold_nx  = 8'd0;
            if (m0_req || m1_req) begin
                win     = rr_pick(m0_req, m1_req, last_grant);
                gnt0_c  = (win == M0);
                gnt1_c  = (win == M1);
                last_nx = win;
                if ((win == M0) ? m0_lock : m1_lock) begin
                    state_nx = (win == M0) ? OWN_M0 : OWN_M1;
                    hold_nx  = 8'd1;
                end
            end
        end
    end

    assign m0_gnt = gnt0_c & rst_n;
    assign m1_gnt = gnt1_c & rst_n;

    assign mem_write = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    assign mem_read  = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
    assign mem_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : '0);
    assign mem_wdata = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : '0);

    assign rd0_p0 = m0_gnt & ~m0_we;
    assign rd1_p0 = m1_gnt & ~m1_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= M1;
            hold_cnt   <= 8'd0;
        end else begin
            state      <= state_nx;
            last_grant <= last_nx;
            hold_cnt   <= hold_nx;
        end
    end

    // Read return stage: capture memory data at the end of the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= rd0_p0;
            m1_rvalid <= rd1_p0;
            if (rd0_p0) m0_rdata <= mem_rdata;
            if (rd1_p0) m1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a memory model and a read-response scoreboard.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        preload;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] last_rd [2];

    typedef struct {
        logic        mst;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    int vecs = 0;
    int errs = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            last_rd[e.mst] = e.data;
            if (e.mst == 1'b0) begin
                chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'd1);
                chk({tag, ".m0_rdata"},  m0_rdata, e.data);
                chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'd0);
                chk({tag, ".m1_rdata_hold"}, m1_rdata, last_rd[1]);
            end else begin
                chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'd1);
                chk({tag, ".m1_rdata"},  m1_rdata, e.data);
                chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'd0);
                chk({tag, ".m0_rdata_hold"}, m0_rdata, last_rd[0]);
            end
        end else begin
            chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'd0);
            chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'd0);
        end
    endtask

    // Starts at posedge+1: drive, check combinational grant/mux mid-cycle, then check responses.
    task automatic cycle(input logic r0, input logic w0, input logic l0,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic eg0, input logic eg1, input string tag);
        logic        ew, er;
        logic [31:0] ea, ed;
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        #4;
        ew = (eg0 & w0) | (eg1 & w1);
        er = (eg0 & ~w0) | (eg1 & ~w1);
        ea = eg0 ? a0 : (eg1 ? a1 : 32'd0);
        ed = eg0 ? d0 : (eg1 ? d1 : 32'd0);
        chk({tag, ".m0_gnt"},    32'(m0_gnt),    32'(eg0));
        chk({tag, ".m1_gnt"},    32'(m1_gnt),    32'(eg1));
        chk({tag, ".mem_write"}, 32'(mem_write), 32'(ew));
        chk({tag, ".mem_read"},  32'(mem_read),  32'(er));
        chk({tag, ".mem_addr"},  mem_addr,  ea);
        chk({tag, ".mem_wdata"}, mem_wdata, ed);
        if (eg0 || eg1) begin
            if (ew) ref_mem[ea[9:2]] = ed;
            else    sbq.push_back('{mst: eg1, data: ref_mem[ea[9:2]]});
        end
        @(posedge clk);
        #1;
        check_rsp(tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        rst_n = 1'b0;
        preload = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b0; m0_addr = 32'h40; m0_wdata = 32'h12345678;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'h0;  m1_wdata = 32'h0;

        #3;
        chk("rst.m0_gnt",    32'(m0_gnt),    32'd0);
        chk("rst.mem_write", 32'(mem_write), 32'd0);
        chk("rst.m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst.m0_rdata",  m0_rdata, 32'd0);
        chk("rst.m1_rdata",  m1_rdata, 32'd0);
        @(posedge clk); #1;
        preload = 1'b0;
        @(posedge clk); #1;
        chk("rst2.mem_write", 32'(mem_write), 32'd0);
        chk("rst2.m1_rvalid", 32'(m1_rvalid), 32'd0);
        rst_n = 1'b1;

        // Round robin on continuous contention, first tie to m0.
        cycle(1,0,0,32'h00,0, 1,0,0,32'h04,0, 1,0, "rr0");
        cycle(1,0,0,32'h08,0, 1,0,0,32'h04,0, 0,1, "rr1");
        cycle(1,0,0,32'h08,0, 1,0,0,32'h0C,0, 1,0, "rr2");
        cycle(1,0,0,32'h10,0, 1,0,0,32'h0C,0, 0,1, "rr3");
        cycle(1,0,0,32'h10,0, 0,0,0,32'h00,0, 1,0, "rd_dead");
        cycle(0,0,0,32'h00,0, 0,0,0,32'h00,0, 0,0, "idle0");

        // m1 write then m0 read-back; 0x40 must not hold the write driven during reset.
        cycle(0,0,0,32'h00,0, 1,1,0,32'h20,32'h55, 0,1, "wr55");
        cycle(1,0,0,32'h20,0, 0,0,0,32'h00,0, 1,0, "rd55");
        cycle(0,0,0,32'h00,0, 1,0,0,32'h40,0, 0,1, "rd40");

        // Locked m0 with m1 waiting, MAX_HOLD=4.
        cycle(1,0,1,32'h100,0, 1,0,0,32'h200,0, 1,0, "lock1");
        cycle(1,0,1,32'h104,0, 1,0,0,32'h200,0, 1,0, "lock2");
        cycle(1,0,1,32'h108,0, 1,0,0,32'h200,0, 1,0, "lock3");
        cycle(1,0,1,32'h10C,0, 1,0,0,32'h200,0, 1,0, "lock4");
        cycle(1,0,1,32'h110,0, 1,0,0,32'h200,0, 0,1, "yield");
        cycle(1,0,1,32'h110,0, 1,0,0,32'h204,0, 1,0, "regain");

        // Owner drops req: m1 granted without a bubble, then plain round robin.
        cycle(0,0,0,32'h000,0, 1,0,0,32'h204,0, 0,1, "drop");
        cycle(1,0,0,32'h114,0, 1,0,0,32'h208,0, 1,0, "idle_rr0");
        cycle(1,0,0,32'h118,0, 1,0,0,32'h208,0, 0,1, "idle_rr1");

        // Reset during a locked burst with a read in flight.
        cycle(1,0,1,32'h11C,0, 1,0,0,32'h20C,0, 1,0, "pre_rst");
        m0_addr = 32'h120;
        #4;
        chk("own.m0_gnt", 32'(m0_gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.m0_gnt",    32'(m0_gnt),    32'd0);
        chk("arst.m1_gnt",    32'(m1_gnt),    32'd0);
        chk("arst.mem_read",  32'(mem_read),  32'd0);
        chk("arst.m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("arst.m0_rdata",  m0_rdata, 32'd0);
        @(posedge clk); #1;
        chk("arst2.m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("arst2.m1_rvalid", 32'(m1_rvalid), 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        rst_n = 1'b1;

        cycle(1,0,0,32'h120,0, 1,0,0,32'h20C,0, 1,0, "post_tie0");
        cycle(0,0,0,32'h000,0, 1,0,0,32'h20C,0, 0,1, "post_tie1");
        cycle(0,0,0,32'h000,0, 0,0,0,32'h000,0, 0,0, "idle1");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
